// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART byte transmitter between NUM_REQ requesters.
// Optional owner-stall eviction is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 234,
    parameter int TIMEOUT_CYCLES = 2700000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } arbState;

    arbState          state;
    logic [PTR_W-1:0] rrPtr;
    logic [PTR_W-1:0] ownerIdx;
    logic [PTR_W-1:0] winIdx;
    logic [PTR_W-1:0] nextPtr;
    logic [PTR_W:0]   scanSum;
    logic [GAP_W-1:0] gapCnt;
    logic             ownerLast;
    logic             handshake;
    logic             evict;
    logic             releaseNow;

    // The byte path is a pure mux on the registered grant, so bytes pass with no added latency.
    assign tx_valid  = |(grant & req_valid);
    assign req_ready = grant & {NUM_REQ{tx_ready}};
    assign ownerLast = |(grant & req_last);
    assign handshake = tx_valid && tx_ready;

    always_comb begin
        // NOTE: defaults first; an always_comb path that leaves a variable unassigned infers a latch.
        tx_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                tx_data = req_data[8*i +: 8];
            end
        end
    end

    // Scan in reverse priority order so the requester closest to rrPtr is written last and wins.
    always_comb begin
        winIdx  = rrPtr;
        scanSum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scanSum = {1'b0, rrPtr} + (PTR_W+1)'(i);
            if (scanSum >= (PTR_W+1)'(NUM_REQ)) begin
                scanSum = scanSum - (PTR_W+1)'(NUM_REQ);
            end
            if (req_valid[scanSum[PTR_W-1:0]]) begin
                winIdx = scanSum[PTR_W-1:0];
            end
        end
    end

    assign nextPtr    = (ownerIdx == PTR_W'(NUM_REQ - 1)) ? '0 : ownerIdx + 1'b1;
    assign releaseNow = (state == XFER) && ((handshake && ownerLast) || evict);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] stallCnt;
    logic            timeoutPulse;

    // Only cycles where the owner has nothing to offer count; serializer backpressure never does.
    assign evict       = (state == XFER) && !tx_valid && (stallCnt == TO_LAST);
    assign timeout_err = timeoutPulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt     <= '0;
            timeoutPulse <= 1'b0;
        end else begin
            timeoutPulse <= evict;
            if (state != XFER || tx_valid || evict) begin
                stallCnt <= '0;
            end else begin
                stallCnt <= stallCnt + 1'b1;
            end
        end
    end
`else
    assign evict       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            ownerIdx <= '0;
            rrPtr    <= '0;
            gapCnt   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant    <= NUM_REQ'(1) << winIdx;
                        ownerIdx <= winIdx;
                        state    <= XFER;
                        busy     <= 1'b1;
                    end
                end
                XFER: begin
                    if (releaseNow) begin
                        grant  <= '0;
                        rrPtr  <= nextPtr;
                        gapCnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        gapCnt <= '0;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, expected bytes are popped on each TX handshake.
// With UART_TX_ARB_TIMEOUT_EN defined the stall test becomes an eviction test with TIMEOUT_CYCLES=16.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 234;
`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_CYC  = 16;
`else
    localparam int TO_CYC  = 2700000;
`endif

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic [7:0] data;
    } expItem;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_err;

    expItem             expQ [$];
    logic [8:0]         srcQ [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold = '0;
    int                 nChecks = 0;
    int                 nPass = 0;
    int                 hsCount = 0;
    int                 holdErrs = 0;
    bit                 bpMode = 1'b0;
    bit                 trackHold = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte k of a packet is bytes[8*(n-1-k) +: 8], so 32'h4C7573 with n=3 sends 4C, 75, 73.
    task automatic queuePkt(input int idx, input int n, input logic [31:0] bytes);
        for (int k = 0; k < n; k++) begin
            srcQ[idx].push_back({(k == n - 1), bytes[8*(n-1-k) +: 8]});
        end
    endtask

    task automatic expectPkt(input int idx, input int n, input logic [31:0] bytes);
        expItem e;
        for (int k = 0; k < n; k++) begin
            e.idx  = 3'(idx);
            e.last = (k == n - 1);
            e.data = bytes[8*(n-1-k) +: 8];
            expQ.push_back(e);
        end
    endtask

    task automatic sendPkt(input int idx, input int n, input logic [31:0] bytes);
        queuePkt(idx, n, bytes);
        expectPkt(idx, n, bytes);
    endtask

    task automatic waitGrant(input string tag, input logic [NUM_REQ-1:0] want, input int budget);
        int n = 0;
        while (grant !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(grant), 32'(want));
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(expQ.size() == 0 && !busy), 32'd1);
    endtask

    // Requester and serializer model: samples at negedge, updates drives 1 time unit after posedge.
    initial begin
        logic [NUM_REQ-1:0] fireMask;
        logic [8:0]         head;
        logic               prevStall;
        logic [7:0]         prevData;
        int                 bpCnt;
        expItem             e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        bpCnt     = 0;
        prevStall = 1'b0;
        prevData  = '0;
        forever begin
            @(negedge clk);
            fireMask = req_valid & req_ready;
            if (tx_valid && tx_ready) begin
                hsCount++;
                check("sb_has_entry", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("sb_data", 32'(tx_data), 32'(e.data));
                    check("sb_grant", 32'(grant), 32'd1 << e.idx);
                    check("sb_ready", 32'(req_ready), 32'd1 << e.idx);
                end
            end
            if (trackHold && prevStall && tx_valid && tx_data !== prevData) begin
                holdErrs++;
            end
            prevStall = tx_valid && !tx_ready;
            prevData  = tx_data;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fireMask[i] && srcQ[i].size() > 0) begin
                    void'(srcQ[i].pop_front());
                end
                if (srcQ[i].size() > 0 && !hold[i]) begin
                    head               = srcQ[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]        = head[8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            if (bpMode) begin
                tx_ready = (bpCnt == 0);
                bpCnt    = (bpCnt == GAP - 1) ? 0 : bpCnt + 1;
            end else begin
                tx_ready = 1'b1;
                bpCnt    = 0;
            end
        end
    end

    initial begin
        int n;
        int errs;
        int hsBase;
        expItem e;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({tx_valid, tx_data, req_ready, grant, busy, timeout_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({tx_valid, req_ready, grant, busy}), 32'd0);

        // Single requester, three bytes, then the idle gap.
        sendPkt(2, 3, 32'h4C7573);
        @(negedge clk);
        check("t1_req_no_grant_yet", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_byte0", 32'(tx_data), 32'h4C);
        @(negedge clk);
        check("t1_byte1", 32'(tx_data), 32'h75);
        @(negedge clk);
        check("t1_byte2", 32'(tx_data), 32'h73);
        @(negedge clk);
        check("t1_gap_state", 32'({grant, busy, tx_valid}), 32'b0000_1_0);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("t1_gap_len", n, GAP);
        check("t1_back_idle", 32'({grant, busy}), 32'd0);

        // Contention from a fresh round-robin pointer.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        queuePkt(3, 2, 32'hD1D2);
        queuePkt(0, 2, 32'h0102);
        expectPkt(0, 2, 32'h0102);
        expectPkt(3, 2, 32'hD1D2);
        waitGrant("t2_req0_first", 4'b0001, 10);
        errs = 0;
        n    = 0;
        while (grant == 4'b0001 && n < 50) begin
            if (req_ready[3]) errs++;
            @(negedge clk);
            n++;
        end
        check("t2_req3_blocked", errs, 0);
        waitGrant("t2_req3_next", 4'b1000, 400);
        waitIdle("t2_drain", 400);

        // Fairness: every requester keeps two single-byte packets pending.
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int p = 0; p < 2; p++) queuePkt(i, 1, 32'hA0 + 32'(16 * p + i));
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REQ; i++) expectPkt(i, 1, 32'hA0 + 32'(16 * p + i));
        end
        for (int k = 0; k < 6; k++) begin
            waitGrant($sformatf("t3_order%0d", k), NUM_REQ'(1 << (k % NUM_REQ)), 300);
            n = 0;
            while (grant != '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        waitIdle("t3_drain", 3000);

        // Backpressure: serializer accepts one byte per GAP cycles.
        hsBase    = hsCount;
        holdErrs  = 0;
        bpMode    = 1'b1;
        trackHold = 1'b1;
        sendPkt(1, 3, 32'h112233);
        waitIdle("t4_drain", 3000);
        check("t4_handshakes", hsCount - hsBase, 3);
        check("t4_hold_stable", holdErrs, 0);
        bpMode    = 1'b0;
        trackHold = 1'b0;
        @(negedge clk);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Owner stalls after its first byte and is evicted; the waiting requester follows.
        queuePkt(0, 3, 32'h616263);
        e.idx  = 3'd0;
        e.last = 1'b0;
        e.data = 8'h61;
        expQ.push_back(e);
        sendPkt(1, 1, 32'h71);
        waitGrant("to_grant0", 4'b0001, 10);
        hold[0] = 1'b1;
        @(negedge clk);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_stall_len", n, 16);
        check("to_grant_clear", 32'(grant), 32'd0);
        srcQ[0].delete();
        hold[0] = 1'b0;
        @(negedge clk);
        check("to_pulse_1cyc", 32'(timeout_err), 32'd0);
        waitIdle("to_drain", 400);

        sendPkt(2, 3, 32'h515253);
        waitGrant("t5_grant", 4'b0100, 10);
        @(negedge clk);
        check("t5_mid_packet", 32'(tx_valid), 32'd1);
`else
        // Owner drops valid for 1000 cycles after its first byte; the lock must hold.
        sendPkt(2, 3, 32'h515253);
        waitGrant("t5_grant", 4'b0100, 10);
        hold[2] = 1'b1;
        @(negedge clk);
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (grant !== 4'b0100 || timeout_err || tx_valid) errs++;
        end
        check("t5_lock_held", errs, 0);
        check("t5_sb_pending", expQ.size(), 2);
        hold[2] = 1'b0;
        @(negedge clk);
        check("t5_mid_packet", 32'(tx_valid), 32'd1);
`endif

        // Reset while a byte is being offered: outputs must clear without waiting for a clock.
        rst_n = 1'b0;
        #1;
        check("t5_rst_async", 32'({tx_valid, tx_data, req_ready, grant, busy, timeout_err}), 32'd0);
        expQ.delete();
        for (int i = 0; i < NUM_REQ; i++) srcQ[i].delete();
        hold = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        queuePkt(3, 1, 32'h83);
        queuePkt(1, 1, 32'h81);
        expectPkt(1, 1, 32'h81);
        expectPkt(3, 1, 32'h83);
        waitGrant("t5_rr_reset", 4'b0010, 10);
        waitIdle("t5_drain", 1000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
